// File: rtl/fifo_ctrl_pkg.sv
// Shared defaults, flag-bit positions and the flag derivation helper
// for the FIFO controller and its RAM users.
package fifo_ctrl_pkg;

  localparam int AWIDTH_DEF = 9;
  localparam int DWIDTH_DEF = 16;

  // Bit positions inside the registered flag vector
  localparam int FLG_FULL   = 0;
  localparam int FLG_EMPTY  = 1;
  localparam int FLG_AFULL  = 2;
  localparam int FLG_AEMPTY = 3;
  localparam int FLG_N      = 4;

  // Pointer instance selectors
  localparam int PTR_WR = 0;
  localparam int PTR_RD = 1;

  // Status flags for a given occupancy
  function automatic logic [FLG_N-1:0] calc_flags(input int cnt, input int depth,
                                                  input int af, input int ae);
    logic [FLG_N-1:0] f;
    f             = '0;
    f[FLG_FULL]   = (cnt == depth);
    f[FLG_EMPTY]  = (cnt == 0);
    f[FLG_AFULL]  = (cnt >= af);
    f[FLG_AEMPTY] = (cnt <= ae);
    return f;
  endfunction

endpackage

// File: rtl/dualport_ram.sv
// Simple dual-port RAM: synchronous write, synchronous read with a
// one-cycle data-valid strobe.
module dualport_ram #(
  parameter int AWIDTH = 9,
  parameter int DWIDTH = 16
) (
  input  logic              wclk,
  input  logic              wen,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              ren,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata,
  output logic              rdv
);

  logic [DWIDTH-1:0] r_mem [2**AWIDTH];

  // Write port
  always_ff @(posedge wclk) begin
    if (wen) r_mem[waddr] <= wdata;
  end

  // Read data register, held between reads
  always_ff @(posedge rclk) begin
    if (ren) rdata <= r_mem[raddr];
  end

  // Read valid marks the cycle after an accepted read
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) rdv <= 1'b0;
    else         rdv <= ren;
  end

endmodule

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: W bits, the MSB acts as the wrap marker.
module fifo_ptr #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_ptr
);

  logic [W-1:0] r_ptr;

  // Advance by one on each accepted access; natural overflow wraps to 0
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_ptr <= '0;
    else         r_ptr <= r_ptr + {{(W-1){1'b0}}, i_inc};
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO controller driving one dual-port RAM. Tracks
// occupancy, registered status flags and sticky over/underflow errors.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AF_LVL = 2**AWIDTH - 4,
  parameter int AE_LVL = 4
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  input  logic              clr_err,
  output logic              ram_wen,
  output logic [AWIDTH-1:0] ram_waddr,
  output logic [DWIDTH-1:0] ram_wdata,
  output logic              ram_ren,
  output logic [AWIDTH-1:0] ram_raddr,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AWIDTH:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 2**AWIDTH;
  localparam logic [FLG_N-1:0] FLAGS_RST = calc_flags(0, DEPTH, AF_LVL, AE_LVL);

  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic [1:0]            w_inc;
  logic [1:0][AWIDTH:0]  w_ptr;
  logic [AWIDTH:0]       w_count_nxt;
  logic [FLG_N-1:0]      w_flags_nxt;
  logic                  w_ovf_nxt;
  logic                  w_unf_nxt;
  logic [AWIDTH:0]       r_count;
  logic [FLG_N-1:0]      r_flags;
  logic                  r_ovf;
  logic                  r_unf;

  // Accept rules come from registered flags only; a push into an empty
  // FIFO is never forwarded to a same-cycle pop.
  assign w_pop_ok  = pop & ~r_flags[FLG_EMPTY];
  assign w_push_ok = push & (~r_flags[FLG_FULL] | w_pop_ok);

  assign w_inc[PTR_WR] = w_push_ok;
  assign w_inc[PTR_RD] = w_pop_ok;

  for (genvar g = 0; g < 2; g++) begin : g_ptr
    fifo_ptr #(.W(AWIDTH+1)) u_ptr (
      .clk    (clk),
      .arst_n (arst_n),
      .i_inc  (w_inc[g]),
      .o_ptr  (w_ptr[g])
    );
  end

  assign ram_wen   = w_push_ok;
  assign ram_waddr = w_ptr[PTR_WR][AWIDTH-1:0];
  assign ram_wdata = push_data;
  assign ram_ren   = w_pop_ok;
  assign ram_raddr = w_ptr[PTR_RD][AWIDTH-1:0];

  // Next occupancy, flags and error state
  always_comb begin
    w_count_nxt = r_count + {{AWIDTH{1'b0}}, w_push_ok} - {{AWIDTH{1'b0}}, w_pop_ok};
    w_flags_nxt = calc_flags(int'(w_count_nxt), DEPTH, AF_LVL, AE_LVL);
    w_ovf_nxt   = (r_ovf & ~clr_err) | (push & ~w_push_ok);
    w_unf_nxt   = (r_unf & ~clr_err) | (pop & ~w_pop_ok);
  end

  // Occupancy, flags and sticky errors; reset discards all contents
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_count <= '0;
      r_flags <= FLAGS_RST;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_flags <= w_flags_nxt;
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
    end
  end

  assign count        = r_count;
  assign full         = r_flags[FLG_FULL];
  assign empty        = r_flags[FLG_EMPTY];
  assign almost_full  = r_flags[FLG_AFULL];
  assign almost_empty = r_flags[FLG_AEMPTY];
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a dualport_ram attached (depth 8).
module tb_fifo_ctrl;

  localparam int AW = 3;
  localparam int DW = 8;

  logic          clk;
  logic          arst_n;
  logic          push;
  logic [DW-1:0] push_data;
  logic          pop;
  logic          clr_err;
  logic          ram_wen;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic          ram_ren;
  logic [AW-1:0] ram_raddr;
  logic          full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;
  logic [DW-1:0] rdata;
  logic          rdv;

  int total = 0;
  int bad   = 0;

  fifo_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .AF_LVL(6), .AE_LVL(1)) dut (
    .clk(clk), .arst_n(arst_n), .push(push), .push_data(push_data), .pop(pop),
    .clr_err(clr_err), .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_ren(ram_ren), .ram_raddr(ram_raddr), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  dualport_ram #(.AWIDTH(AW), .DWIDTH(DW)) u_ram (
    .wclk(clk), .wen(ram_wen), .waddr(ram_waddr), .wdata(ram_wdata),
    .rclk(clk), .rrst_n(arst_n), .ren(ram_ren), .raddr(ram_raddr),
    .rdata(rdata), .rdv(rdv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic pu, input logic [7:0] d, input logic po, input logic ce);
    push = pu; push_data = d; pop = po; clr_err = ce;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_d;
    int sent, got, mcnt;
    logic pu, po, puk, pok;

    push = 0; push_data = 0; pop = 0; clr_err = 0; arst_n = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    arst_n = 1;

    // 1: fill with 0x10..0x17
    for (int i = 0; i < 8; i++) begin
      drive(1, 8'(32'h10 + i), 0, 0);
      chk("fill_wen", ram_wen, 1);
      chk("fill_waddr", ram_waddr, i);
      tick();
      chk("fill_count", count, i + 1);
      chk("fill_full", full, (i + 1 == 8));
      chk("fill_af", almost_full, (i + 1 >= 6));
      chk("fill_ae", almost_empty, (i + 1 <= 1));
      chk("fill_empty", empty, 0);
    end
    chk("fill_ovf", overflow, 0);

    // 2: push while full is rejected
    drive(1, 8'h99, 0, 0);
    chk("ovf_wen", ram_wen, 0);
    tick();
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 8);
    drive(0, 8'h00, 0, 1);
    tick();
    chk("ovf_clr", overflow, 0);

    // 3: drain, data in order one cycle after each pop
    for (int i = 0; i < 8; i++) begin
      drive(0, 8'h00, 1, 0);
      chk("pop_ren", ram_ren, 1);
      chk("pop_raddr", ram_raddr, i);
      tick();
      chk("pop_rdv", rdv, 1);
      chk("pop_rdata", rdata, 32'h10 + i);
      chk("pop_count", count, 7 - i);
    end
    chk("drain_empty", empty, 1);
    drive(0, 8'h00, 1, 0);
    chk("unf_ren", ram_ren, 0);
    tick();
    chk("unf_set", underflow, 1);
    chk("unf_rdv", rdv, 0);
    drive(0, 8'h00, 0, 1);
    tick();
    chk("unf_clr", underflow, 0);

    // 4: streaming across pointer wrap
    sent = 0; got = 0; mcnt = 0;
    for (int c = 0; c < 100 && got < 20; c++) begin
      pu  = (sent < 20) && (c % 4 != 3);
      po  = (mcnt > 0) && ((c % 3 != 0) || sent == 20);
      pok = po && (mcnt > 0);
      puk = pu && (mcnt < 8 || pok);
      drive(pu, 8'(32'h40 + sent), po, 0);
      chk("st_wen", ram_wen, puk);
      tick();
      if (pok) begin
        exp_d = q.pop_front();
        chk("st_rdata", rdata, exp_d);
        got++;
      end
      if (puk) begin
        q.push_back(8'(32'h40 + sent));
        sent++;
      end
      mcnt = mcnt + (puk ? 1 : 0) - (pok ? 1 : 0);
      chk("st_rdv", rdv, pok);
      chk("st_count", count, mcnt);
      chk("st_le8", (count <= 8), 1);
    end
    chk("st_done", got, 20);
    chk("st_empty", empty, 1);

    // 5a: full + simultaneous push/pop
    for (int i = 0; i < 8; i++) begin
      drive(1, 8'(32'h50 + i), 0, 0);
      tick();
    end
    chk("f5_full", full, 1);
    drive(1, 8'h60, 1, 0);
    chk("f5_wen", ram_wen, 1);
    chk("f5_ren", ram_ren, 1);
    tick();
    chk("f5_count", count, 8);
    chk("f5_full2", full, 1);
    chk("f5_rdata", rdata, 8'h50);
    chk("f5_ovf", overflow, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 8'h00, 1, 0);
      tick();
      chk("f5_drain", rdata, (i == 7) ? 32'h60 : 32'h51 + i);
    end
    chk("f5_empty", empty, 1);

    // 5b: empty + simultaneous push/pop: only push accepted
    drive(1, 8'h70, 1, 0);
    chk("e5_wen", ram_wen, 1);
    chk("e5_ren", ram_ren, 0);
    tick();
    chk("e5_count", count, 1);
    chk("e5_unf", underflow, 1);
    chk("e5_rdv", rdv, 0);

    // 6: asynchronous reset mid-stream
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'(32'h71 + i), 0, 0);
      tick();
    end
    chk("r6_count5", count, 5);
    arst_n = 0;
    #2;
    chk("r6_count", count, 0);
    chk("r6_empty", empty, 1);
    chk("r6_ae", almost_empty, 1);
    chk("r6_unf", underflow, 0);
    arst_n = 1;
    drive(1, 8'hA5, 0, 0);
    chk("r6_waddr", ram_waddr, 0);
    chk("r6_wen", ram_wen, 1);
    tick();
    chk("r6_count1", count, 1);
    drive(0, 8'h00, 1, 0);
    chk("r6_raddr", ram_raddr, 0);
    tick();
    chk("r6_rdv", rdv, 1);
    chk("r6_rdata", rdata, 8'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
